// File: rtl/conv_frame_encoder.sv
// conv_frame_encoder: rate-1/2, K=3 convolutional encoder (generators 7/5 octal).
// Accepts FRAME_BITS-bit message frames over valid/ready and emits one
// {c0, c1} code symbol per transfer, MSB of the frame first.
// Build option: define CONV_ENC_TAIL_EN to append two zero tail bits per
// frame, which returns the trellis to state 00 at every frame boundary.
// Without it the trellis state carries over from frame to frame.
//
// state | meaning
// IDLE  | waiting for a frame; frame_ready high, no symbol presented
// SEND  | presenting symbols for message bits 0..FRAME_BITS-1
// TAIL  | presenting symbols for the two forced-zero tail bits (tail builds only)

module conv_frame_encoder #(
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refresh,
  input  logic [FRAME_BITS-1:0] frame_in,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [1:0]            sym_out,
  output logic                  sym_valid,
  input  logic                  sym_ready,
  output logic                  sym_last,
  output logic [3:0]            sym_index,
  output logic [1:0]            enc_state
);

  localparam logic [3:0] LAST_MSG = 4'(FRAME_BITS - 1);
`ifdef CONV_ENC_TAIL_EN
  localparam logic [3:0] LAST_SYM = 4'(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, TAIL = 2'd2} fsm_t;
`else
  localparam logic [3:0] LAST_SYM = LAST_MSG;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} fsm_t;
`endif

  fsm_t                  fsm;
  logic [FRAME_BITS-1:0] shreg;

  logic       u_cur;
  logic       u_nxt;
  logic [1:0] st_nxt;
  logic [1:0] sym_nxt;
  logic [3:0] idx_nxt;
  logic       xfer;

  // Code symbol {c0, c1} for input bit u leaving trellis state {s1, s0}.
  function automatic logic [1:0] code_sym(input logic u, input logic [1:0] st);
    return {u ^ st[1] ^ st[0], u ^ st[0]};
  endfunction

  // The shift register supplies the current and following message bits;
  // zeros shift in behind the frame, so tail bits come out as u=0 for free.
  always_comb begin
    u_cur   = shreg[FRAME_BITS-1];
    u_nxt   = shreg[FRAME_BITS-2];
    st_nxt  = {u_cur, enc_state[1]};
    sym_nxt = code_sym(u_nxt, st_nxt);
    idx_nxt = sym_index + 4'd1;
    xfer    = sym_valid & sym_ready;
  end

  assign frame_ready = (fsm == IDLE);

  // Frame sequencer: accepts a frame, then advances one trellis step per
  // symbol transfer, holding everything while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      shreg     <= '0;
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
      sym_index <= 4'd0;
      enc_state <= 2'b00;
    end else if (refresh) begin
      fsm       <= IDLE;
      shreg     <= '0;
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
      sym_index <= 4'd0;
      enc_state <= 2'b00;
    end else begin
      case (fsm)
        IDLE: begin
          if (frame_valid) begin
            shreg     <= frame_in;
            sym_out   <= code_sym(frame_in[FRAME_BITS-1], enc_state);
            sym_valid <= 1'b1;
            sym_index <= 4'd0;
            sym_last  <= (LAST_SYM == 4'd0);
            fsm       <= SEND;
          end
        end
`ifdef CONV_ENC_TAIL_EN
        SEND, TAIL: begin
`else
        SEND: begin
`endif
          if (xfer) begin
            enc_state <= st_nxt;
            shreg     <= {shreg[FRAME_BITS-2:0], 1'b0};
            if (sym_index == LAST_SYM) begin
              fsm       <= IDLE;
              sym_valid <= 1'b0;
              sym_last  <= 1'b0;
              sym_index <= 4'd0;
            end else begin
              sym_out   <= sym_nxt;
              sym_index <= idx_nxt;
              sym_last  <= (idx_nxt == LAST_SYM);
`ifdef CONV_ENC_TAIL_EN
              if (sym_index == LAST_MSG) fsm <= TAIL;
`endif
            end
          end
        end
        default: begin
          fsm       <= IDLE;
          sym_valid <= 1'b0;
          sym_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Testbench for conv_frame_encoder: directed and randomized frames checked
// against a trellis reference model evaluated with integer arithmetic.
// Honours CONV_ENC_TAIL_EN the same way the design does.

module tb_conv_frame_encoder;

  localparam int FB = 8;
`ifdef CONV_ENC_TAIL_EN
  localparam int NTAIL = 2;
`else
  localparam int NTAIL = 0;
`endif
  localparam int NSYM = FB + NTAIL;

  logic          clk;
  logic          rst;
  logic          refresh;
  logic [FB-1:0] frame_in;
  logic          frame_valid;
  logic          frame_ready;
  logic [1:0]    sym_out;
  logic          sym_valid;
  logic          sym_ready;
  logic          sym_last;
  logic [3:0]    sym_index;
  logic [1:0]    enc_state;

  int vectors = 0;
  int miscompares = 0;

  int model_state;
  int exp_sym [NSYM];
  int exp_st  [NSYM];
  int exp_end;

  conv_frame_encoder #(.FRAME_BITS(FB)) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh    (refresh),
    .frame_in   (frame_in),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_last   (sym_last),
    .sym_index  (sym_index),
    .enc_state  (enc_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the trellis bit by bit. State is an integer 0..3 whose
  // high bit is the most recent input; outputs are parities of tapped bits.
  task automatic build_expect(input logic [FB-1:0] f);
    int st;
    int u;
    int s1;
    int s0;
    st = model_state;
    for (int i = 0; i < NSYM; i++) begin
      u  = (i < FB) ? int'(f[FB-1-i]) : 0;
      s1 = st / 2;
      s0 = st % 2;
      exp_st[i]  = st;
      exp_sym[i] = ((u + s1 + s0) % 2) * 2 + ((u + s0) % 2);
      st = u * 2 + s1;
    end
    exp_end = st;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, sym_valid, 0);
    check({tag, "_ready"}, frame_ready, 1);
    check({tag, "_state"}, enc_state, 0);
    check({tag, "_index"}, sym_index, 0);
    check({tag, "_sym"},   sym_out, 0);
    check({tag, "_last"},  sym_last, 0);
  endtask

  // Sends one frame and checks every presented symbol. abort_kind 1 pulses
  // refresh when symbol abort_at is presented, abort_kind 2 pulses async rst.
  task automatic run_frame(input logic [FB-1:0] f, input int stall_at, input int stall_len,
                           input int abort_at, input int abort_kind, input bit rnd);
    int i;
    int stalled;
    bit rdy;
    check("idle_ready", frame_ready, 1);
    check("idle_valid", sym_valid, 0);
    build_expect(f);
    frame_in    = f;
    frame_valid = 1'b1;
    sym_ready   = 1'($urandom);
    @(negedge clk);
    frame_valid = 1'b0;
    frame_in    = FB'($urandom);
    i = 0;
    stalled = 0;
    while (i < NSYM) begin
      if (i == abort_at && abort_kind == 1) begin
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        check_cleared("refresh");
        model_state = 0;
        return;
      end
      if (i == abort_at && abort_kind == 2) begin
        #2 rst = 1'b1;
        #1 check("async_rst_valid", sym_valid, 0);
        check("async_rst_ready", frame_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        check_cleared("rst");
        model_state = 0;
        return;
      end
      check("sym_valid", sym_valid, 1);
      check("sym_out",   sym_out, 32'(exp_sym[i]));
      check("sym_index", sym_index, 32'(i));
      check("sym_last",  sym_last, 32'(i == NSYM - 1));
      check("enc_state", enc_state, 32'(exp_st[i]));
      check("busy_ready", frame_ready, 0);
      if (i == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      sym_ready   = rdy;
      frame_valid = 1'($urandom);
      frame_in    = FB'($urandom);
      @(negedge clk);
      if (rdy) i++;
    end
    frame_valid = 1'b0;
    check("done_valid", sym_valid, 0);
    check("done_ready", frame_ready, 1);
    check("done_last",  sym_last, 0);
    check("end_state",  enc_state, 32'(exp_end));
    model_state = exp_end;
  endtask

  initial begin
    rst         = 1'b1;
    refresh     = 1'b0;
    frame_in    = '0;
    frame_valid = 1'b0;
    sym_ready   = 1'b0;
    model_state = 0;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("post_reset");

    run_frame(8'b10110000, -1, 0, -1, 0, 1'b0);
    run_frame(8'hFF,       -1, 0, -1, 0, 1'b0);
    run_frame(8'h00,       -1, 0, -1, 0, 1'b0);
    run_frame(8'b10110000,  2, 3, -1, 0, 1'b0);
    run_frame(8'hFF,       -1, 0,  4, 1, 1'b0);
    run_frame(8'hFF,       -1, 0, -1, 0, 1'b0);
    run_frame(8'h00,       -1, 0, -1, 0, 1'b0);
    run_frame(8'h5A,       -1, 0,  6, 2, 1'b0);
    run_frame(8'hC3,       -1, 0, -1, 0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      run_frame(FB'($urandom), -1, 0, -1, 0, 1'b1);
    end
    run_frame(8'hA5, 0, 2, NSYM - 1, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      run_frame(FB'($urandom), NSYM - 1, 2, -1, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
